// File: rtl/score_overlay_gen_if.sv
// Score overlay bus: score capture strobes, pixel coordinates in, overlay pixel and status out.
interface score_overlay_gen_if #(
  parameter int unsigned SCORE_W = 14
);
  logic [SCORE_W-1:0] score;
  logic               score_valid;
  logic               frame_start;
  logic [9:0]         x_pixel;
  logic [9:0]         y_pixel;
  logic [11:0]        score_text;
  logic               text_on;
  logic               busy;

  // Driver side: the video timing / game logic that feeds the renderer.
  modport master (
    output score, score_valid, frame_start, x_pixel, y_pixel,
    input  score_text, text_on, busy
  );

  // Renderer side.
  modport slave (
    input  score, score_valid, frame_start, x_pixel, y_pixel,
    output score_text, text_on, busy
  );
endinterface

// File: rtl/score_overlay_gen.sv
// On-screen score renderer. A binary score is clamped and latched. At most once per frame it is
// converted to BCD by a sequential double-dabble engine. The result is drawn from an 8x8 font,
// scaled by 2^SCALE_LOG2, with leading zeros blanked, through a 2-stage registered pixel pipeline.
// Optional: define SCORE_BLINK_EN to blink the digits for 24 frames after the value changes.
module score_overlay_gen #(
  parameter int unsigned SCORE_W    = 14,
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned TEXT_X     = 500,
  parameter int unsigned TEXT_Y     = 400,
  parameter int unsigned SCALE_LOG2 = 0,
  parameter logic [11:0] FG_COLOR   = 12'hFFF
) (
  input  logic                clk,
  input  logic                reset_n,
  score_overlay_gen_if.slave  bus
);

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int unsigned BcdW  = 4 * DIGITS;
  localparam int unsigned CntW  = $clog2(SCORE_W + 1);
  localparam int unsigned CellW = 8 << SCALE_LOG2;
  localparam logic [SCORE_W-1:0] MaxScore = SCORE_W'(pow10(DIGITS) - 1);
  localparam logic [10:0] XLo  = 11'(TEXT_X);
  localparam logic [10:0] YLo  = 11'(TEXT_Y);
  localparam logic [10:0] BoxW = 11'(DIGITS * CellW);
  localparam logic [10:0] BoxH = 11'(CellW);

  typedef enum logic [1:0] {StIdle, StConvert, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [SCORE_W-1:0]  bin_q, bin_d;
  logic [BcdW-1:0]     bcd_q, bcd_d;
  logic [BcdW-1:0]     disp_q, disp_d;
  logic [SCORE_W-1:0]  pending_q, pending_d;
  logic                dirty_q, dirty_d;
  logic [SCORE_W-1:0]  score_clamped;
  logic [BcdW-1:0]     adj;
  logic [BcdW+SCORE_W-1:0] shifted;
  logic                gate;

  assign score_clamped = (bus.score > MaxScore) ? MaxScore : bus.score;
  assign bus.busy      = (state_q != StIdle);

  // Conversion FSM and capture registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      disp_q    <= '0;
      pending_q <= '0;
      dirty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      dirty_q   <= dirty_d;
    end
  end

  // Next-state: capture, frame-start launch, add-3-then-shift steps, result commit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    dirty_d   = dirty_q;
    adj       = bcd_q;
    shifted   = '0;

    // A score arriving while busy waits in pending for the next frame.
    if (bus.score_valid) begin
      pending_d = score_clamped;
      dirty_d   = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.frame_start && (dirty_q || bus.score_valid)) begin
          // A coincident strobe bypasses pending and is consumed right away.
          bin_d   = bus.score_valid ? score_clamped : pending_q;
          bcd_d   = '0;
          cnt_d   = '0;
          dirty_d = 1'b0;
          state_d = StConvert;
        end
      end
      StConvert: begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        shifted        = {adj, bin_q} << 1;
        {bcd_d, bin_d} = shifted;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CntW'(SCORE_W - 1)) state_d = StDone;
      end
      StDone: begin
        disp_d  = bcd_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef SCORE_BLINK_EN
  logic [4:0] blink_q, blink_d;

  // Blink frame counter: reloaded when a new value is committed, counts down per frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) blink_q <= '0;
    else          blink_q <= blink_d;
  end

  // Counter next-state; a commit takes priority over the frame decrement.
  always_comb begin
    blink_d = blink_q;
    if (bus.frame_start && (blink_q != 5'd0)) blink_d = blink_q - 5'd1;
    if ((state_q == StDone) && (bcd_q != disp_q)) blink_d = 5'd24;
  end

  assign gate = (blink_q != 5'd0) && blink_q[2];
`else
  assign gate = 1'b0;
`endif

  // Render stage 1: box test and glyph coordinates, all relative to the box origin.
  logic [10:0] dx, dy;
  logic        in_box_d, in_box_q;
  logic [2:0]  digit_d, digit_q, row_d, row_q, col_d, col_q;

  always_comb begin
    dx       = {1'b0, bus.x_pixel} - XLo;
    dy       = {1'b0, bus.y_pixel} - YLo;
    in_box_d = ({1'b0, bus.x_pixel} >= XLo) && (dx < BoxW) &&
               ({1'b0, bus.y_pixel} >= YLo) && (dy < BoxH);
    digit_d  = 3'(dx >> (3 + SCALE_LOG2));
    col_d    = 3'(dx >> SCALE_LOG2);
    row_d    = 3'(dy >> SCALE_LOG2);
  end

  // Stage 1 pipeline registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_box_q <= 1'b0;
      digit_q  <= '0;
      row_q    <= '0;
      col_q    <= '0;
    end else begin
      in_box_q <= in_box_d;
      digit_q  <= digit_d;
      row_q    <= row_d;
      col_q    <= col_d;
    end
  end

  // Glyph rows, row 0 in the top byte; row 7 is the inter-line gap.
  function automatic logic [7:0] font_row(input logic [3:0] d, input logic [2:0] r);
    logic [63:0] g;
    case (d)
      4'd0:    g = 64'h3C666E7666663C00;
      4'd1:    g = 64'h1838181818187E00;
      4'd2:    g = 64'h3C66060C30607E00;
      4'd3:    g = 64'h3C66061C06663C00;
      4'd4:    g = 64'h0C1C3C6C7E0C0C00;
      4'd5:    g = 64'h7E607C0606663C00;
      4'd6:    g = 64'h3C60607C66663C00;
      4'd7:    g = 64'h7E060C1830303000;
      4'd8:    g = 64'h3C66663C66663C00;
      4'd9:    g = 64'h3C66663E060C3800;
      default: g = 64'h0;
    endcase
    return g[8*(7 - int'(r)) +: 8];
  endfunction

  // Stage 2: digit select, leading-zero blanking, font lookup and gating.
  logic [DIGITS-1:0] blank_digit;
  logic              zero_run;
  logic [3:0]        nib;
  logic              blank;
  logic [7:0]        glyph;
  logic              lit;

  always_comb begin
    zero_run    = 1'b1;
    blank_digit = '0;
    nib         = '0;
    blank       = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      zero_run       = zero_run && (disp_q[4*(int'(DIGITS)-1-i) +: 4] == 4'd0);
      blank_digit[i] = zero_run && (i != int'(DIGITS) - 1);
      if (digit_q == 3'(i)) begin
        nib   = disp_q[4*(int'(DIGITS)-1-i) +: 4];
        blank = blank_digit[i];
      end
    end
    glyph = font_row(nib, row_q);
    lit   = in_box_q && !blank && glyph[3'd7 - col_q] && !gate;
  end

  logic [11:0] text_q;
  logic        on_q;

  // Stage 2 output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      text_q <= '0;
      on_q   <= 1'b0;
    end else begin
      text_q <= lit ? FG_COLOR : 12'h000;
      on_q   <= lit;
    end
  end

  assign bus.score_text = text_q;
  assign bus.text_on    = on_q;

endmodule

// File: tb/tb_score_overlay_gen.sv
// Directed bench for score_overlay_gen: default instance plus a 2x-scaled instance.
module tb_score_overlay_gen;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  score_overlay_gen_if #(.SCORE_W(14)) bus0 ();
  score_overlay_gen_if #(.SCORE_W(14)) bus1 ();

  score_overlay_gen dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0.slave)
  );

  score_overlay_gen #(.SCALE_LOG2(1)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] Glyph0 = 64'h3C666E7666663C00;

  // Expected pixel with the display at "0" in the default box.
  function automatic logic [11:0] exp_zero(input int x, input int y);
    logic [63:0] g;
    g = Glyph0;
    if (x >= 524 && x < 532 && y >= 400 && y < 408)
      return g[8*(7-(y-400)) + (7-(x-524))] ? 12'hFFF : 12'h000;
    return 12'h000;
  endfunction

  task automatic probe(input bit which, input int x, input int y,
                       output logic [11:0] t, output logic o);
    @(negedge clk);
    if (which) begin
      bus1.x_pixel = 10'(x);
      bus1.y_pixel = 10'(y);
    end else begin
      bus0.x_pixel = 10'(x);
      bus0.y_pixel = 10'(y);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    t = which ? bus1.score_text : bus0.score_text;
    o = which ? bus1.text_on : bus0.text_on;
  endtask

  task automatic send_score(input bit which, input int v);
    @(negedge clk);
    if (which) begin bus1.score = 14'(v); bus1.score_valid = 1'b1; end
    else       begin bus0.score = 14'(v); bus0.score_valid = 1'b1; end
    @(negedge clk);
    bus0.score_valid = 1'b0;
    bus1.score_valid = 1'b0;
  endtask

  task automatic pulse_frame(input bit which);
    @(negedge clk);
    if (which) bus1.frame_start = 1'b1; else bus0.frame_start = 1'b1;
    @(negedge clk);
    bus0.frame_start = 1'b0;
    bus1.frame_start = 1'b0;
  endtask

  // Call right after pulse_frame: counts negedges with busy high, bounded.
  task automatic count_busy(input bit which, output int cyc);
    cyc = 0;
    while ((which ? bus1.busy : bus0.busy) && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [11:0] t;
    logic        o;
    int          bad;
    @(negedge clk);
    n_checks++;
    if (bus0.busy !== 1'b0 || bus0.score_text !== 12'h000 || bus0.text_on !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b text=%h on=%b required 0/000/0",
               bus0.busy, bus0.score_text, bus0.text_on);
    end
    reset_n = 1'b1;
    bad = 0;
    for (int y = 400; y < 408; y++) begin
      for (int x = 500; x < 532; x++) begin
        probe(1'b0, x, y, t, o);
        n_checks++;
        if (t !== exp_zero(x, y) || o !== (exp_zero(x, y) != 12'h000)) begin
          n_fail++;
          $display("FAIL reset_scan (%0d,%0d): got %h/%b required %h", x, y, t, o, exp_zero(x, y));
        end
      end
    end
    probe(1'b0, 532, 400, t, o);
    n_checks++;
    if (t !== 12'h000 || o !== 1'b0) begin
      n_fail++;
      $display("FAIL outside_right: got %h/%b required 000/0", t, o);
    end
    probe(1'b0, 526, 399, t, o);
    n_checks++;
    if (t !== 12'h000 || o !== 1'b0) begin
      n_fail++;
      $display("FAIL outside_above: got %h/%b required 000/0", t, o);
    end
    probe(1'b1, 548 + 4, 400, t, o);
    n_checks++;
    if (t !== 12'hFFF) begin
      n_fail++;
      $display("FAIL reset_scaled_zero: got %h required FFF", t);
    end
  endtask

  // Streaming x along row 400: output must trail the coordinates by exactly two cycles.
  task automatic test_latency();
    int prev_x;
    prev_x = -1;
    bus0.y_pixel = 10'd400;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      bus0.x_pixel = 10'(500 + i);
      @(posedge clk);
      #1;
      if (i >= 2) begin
        n_checks++;
        if (bus0.score_text !== exp_zero(prev_x, 400)) begin
          n_fail++;
          $display("FAIL latency x=%0d: got %h required %h", prev_x, bus0.score_text,
                   exp_zero(prev_x, 400));
        end
      end
      prev_x = 500 + i;
    end
  endtask

  task automatic test_1234();
    int          cyc;
    logic [11:0] t;
    logic        o;
    send_score(1'b0, 1234);
    pulse_frame(1'b0);
    count_busy(1'b0, cyc);
    n_checks++;
    if (cyc !== 15) begin
      n_fail++;
      $display("FAIL busy_len_1234: got %0d cycles required 15", cyc);
    end
    probe(1'b0, 503, 400, t, o);
    n_checks++;
    if (t !== 12'hFFF || o !== 1'b1) begin
      n_fail++;
      $display("FAIL d1_pix: got %h/%b required FFF/1", t, o);
    end
    probe(1'b0, 500, 400, t, o);
    n_checks++;
    if (t !== 12'h000 || o !== 1'b0) begin
      n_fail++;
      $display("FAIL d1_edge: got %h/%b required 000/0", t, o);
    end
    probe(1'b0, 516 + 5, 400, t, o);
    n_checks++;
    if (t !== 12'hFFF) begin
      n_fail++;
      $display("FAIL d3_pix: got %h required FFF", t);
    end
  endtask

  task automatic test_7();
    int          cyc, lit_cnt;
    logic [11:0] t;
    logic        o;
    send_score(1'b0, 7);
    pulse_frame(1'b0);
    count_busy(1'b0, cyc);
    lit_cnt = 0;
    for (int y = 400; y < 408; y++)
      for (int x = 500; x < 524; x++) begin
        probe(1'b0, x, y, t, o);
        if (t !== 12'h000 || o !== 1'b0) lit_cnt++;
      end
    n_checks++;
    if (lit_cnt !== 0) begin
      n_fail++;
      $display("FAIL suppress_7: got %0d lit pixels required 0", lit_cnt);
    end
    probe(1'b0, 525, 400, t, o);
    n_checks++;
    if (t !== 12'hFFF) begin
      n_fail++;
      $display("FAIL seven_col1: got %h required FFF", t);
    end
    probe(1'b0, 524, 400, t, o);
    n_checks++;
    if (t !== 12'h000) begin
      n_fail++;
      $display("FAIL seven_col0: got %h required 000", t);
    end
  endtask

  task automatic test_saturate();
    int          cyc;
    logic [11:0] t;
    logic        o;
    logic [7:0]  row_bits;
    send_score(1'b0, 12000);
    pulse_frame(1'b0);
    count_busy(1'b0, cyc);
    for (int d = 0; d < 4; d++) begin
      row_bits = '0;
      for (int c = 0; c < 8; c++) begin
        probe(1'b0, 500 + 8*d + c, 403, t, o);
        row_bits[7-c] = (t === 12'hFFF);
      end
      n_checks++;
      if (row_bits !== 8'h3E) begin
        n_fail++;
        $display("FAIL sat_digit%0d row3: got %h required 3e", d, row_bits);
      end
    end
  endtask

  task automatic test_pending();
    int          cyc;
    logic [11:0] t;
    logic        o;
    send_score(1'b0, 42);
    probe(1'b0, 503, 403, t, o);
    n_checks++;
    if (t !== 12'hFFF) begin
      n_fail++;
      $display("FAIL no_frame_hold: got %h required FFF", t);
    end
    pulse_frame(1'b0);
    cyc = 0;
    // 55 arrives mid-conversion, then a frame_start that must be ignored.
    while (bus0.busy && cyc < 100) begin
      cyc++;
      if (cyc == 3) begin bus0.score = 14'd55; bus0.score_valid = 1'b1; end
      if (cyc == 4) begin bus0.score_valid = 1'b0; bus0.frame_start = 1'b1; end
      if (cyc == 5) bus0.frame_start = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (cyc !== 15) begin
      n_fail++;
      $display("FAIL busy_ignore_frame: got %0d cycles required 15", cyc);
    end
    probe(1'b0, 520, 400, t, o);
    n_checks++;
    if (t !== 12'hFFF) begin
      n_fail++;
      $display("FAIL show_42_four: got %h required FFF", t);
    end
    probe(1'b0, 517, 400, t, o);
    n_checks++;
    if (t !== 12'h000) begin
      n_fail++;
      $display("FAIL show_42_not55: got %h required 000", t);
    end
    probe(1'b0, 511, 400, t, o);
    n_checks++;
    if (t !== 12'h000) begin
      n_fail++;
      $display("FAIL show_42_blank: got %h required 000", t);
    end
    pulse_frame(1'b0);
    count_busy(1'b0, cyc);
    n_checks++;
    if (cyc !== 15) begin
      n_fail++;
      $display("FAIL busy_len_55: got %0d cycles required 15", cyc);
    end
    probe(1'b0, 517, 400, t, o);
    n_checks++;
    if (t !== 12'hFFF) begin
      n_fail++;
      $display("FAIL show_55: got %h required FFF", t);
    end
  endtask

  task automatic test_bypass();
    int          cyc;
    logic [11:0] t;
    logic        o;
    @(negedge clk);
    bus0.score       = 14'd1;
    bus0.score_valid = 1'b1;
    bus0.frame_start = 1'b1;
    @(negedge clk);
    bus0.score_valid = 1'b0;
    bus0.frame_start = 1'b0;
    count_busy(1'b0, cyc);
    n_checks++;
    if (cyc !== 15) begin
      n_fail++;
      $display("FAIL bypass_busy: got %0d cycles required 15", cyc);
    end
    probe(1'b0, 527, 400, t, o);
    n_checks++;
    if (t !== 12'hFFF) begin
      n_fail++;
      $display("FAIL bypass_one_lit: got %h required FFF", t);
    end
    probe(1'b0, 526, 400, t, o);
    n_checks++;
    if (t !== 12'h000) begin
      n_fail++;
      $display("FAIL bypass_one_dark: got %h required 000", t);
    end
    pulse_frame(1'b0);
    n_checks++;
    if (bus0.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_dirty: busy=%b required 0", bus0.busy);
    end
  endtask

  task automatic test_reset_mid();
    int          cyc;
    logic [11:0] t;
    logic        o;
    probe(1'b0, 527, 400, t, o);
    send_score(1'b0, 1234);
    pulse_frame(1'b0);
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus0.busy !== 1'b1 || bus0.score_text !== 12'hFFF) begin
      n_fail++;
      $display("FAIL pre_reset: busy=%b text=%h required 1/FFF", bus0.busy, bus0.score_text);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus0.busy !== 1'b0 || bus0.score_text !== 12'h000 || bus0.text_on !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b text=%h on=%b required 0/000/0",
               bus0.busy, bus0.score_text, bus0.text_on);
    end
    @(negedge clk);
    reset_n = 1'b1;
    probe(1'b0, 526, 400, t, o);
    n_checks++;
    if (t !== 12'hFFF) begin
      n_fail++;
      $display("FAIL after_reset_zero: got %h required FFF", t);
    end
    probe(1'b0, 503, 400, t, o);
    n_checks++;
    if (t !== 12'h000) begin
      n_fail++;
      $display("FAIL after_reset_blank: got %h required 000", t);
    end
    pulse_frame(1'b0);
    count_busy(1'b0, cyc);
    n_checks++;
    if (cyc !== 0) begin
      n_fail++;
      $display("FAIL after_reset_dirty: got %0d busy cycles required 0", cyc);
    end
  endtask

  task automatic test_scale();
    int          cyc;
    logic [11:0] t;
    logic        o;
    send_score(1'b1, 8);
    pulse_frame(1'b1);
    count_busy(1'b1, cyc);
    n_checks++;
    if (cyc !== 15) begin
      n_fail++;
      $display("FAIL scale_busy: got %0d cycles required 15", cyc);
    end
    probe(1'b1, 552, 400, t, o);
    n_checks++;
    if (t !== 12'hFFF || o !== 1'b1) begin
      n_fail++;
      $display("FAIL scale_lit: got %h/%b required FFF/1", t, o);
    end
    probe(1'b1, 551, 400, t, o);
    n_checks++;
    if (t !== 12'h000) begin
      n_fail++;
      $display("FAIL scale_col1: got %h required 000", t);
    end
    probe(1'b1, 559, 413, t, o);
    n_checks++;
    if (t !== 12'hFFF) begin
      n_fail++;
      $display("FAIL scale_row6: got %h required FFF", t);
    end
    probe(1'b1, 560, 413, t, o);
    n_checks++;
    if (t !== 12'h000) begin
      n_fail++;
      $display("FAIL scale_row6_col6: got %h required 000", t);
    end
    probe(1'b1, 540, 400, t, o);
    n_checks++;
    if (t !== 12'h000) begin
      n_fail++;
      $display("FAIL scale_blank_d2: got %h required 000", t);
    end
  endtask

  initial begin
    reset_n          = 1'b0;
    bus0.score       = '0;
    bus0.score_valid = 1'b0;
    bus0.frame_start = 1'b0;
    bus0.x_pixel     = '0;
    bus0.y_pixel     = '0;
    bus1.score       = '0;
    bus1.score_valid = 1'b0;
    bus1.frame_start = 1'b0;
    bus1.x_pixel     = '0;
    bus1.y_pixel     = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_latency();
    test_1234();
    test_7();
    test_saturate();
    test_pending();
    test_bypass();
    test_reset_mid();
    test_scale();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
